// File: rtl/wb_regfile_if.sv
// Write-back / register-read bundle between the MEM/WB stage, the ID stage and the debug display.
// master drives the write-back operands and read addresses; slave is the register file.
interface wb_regfile_if #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 32
);
   logic             WB_RegWrite;
   logic             WB_MemtoReg;
   logic             WB_link;
   logic [4:0]       WB_rd_addr;
   logic [XLEN-1:0]  WB_ALUResult;
   logic [XLEN-1:0]  WB_MemData;
   logic [XLEN-1:0]  WB_pc4_i;
   logic [4:0]       rs1_addr;
   logic [4:0]       rs2_addr;
   logic [4:0]       dbg_addr;
   logic [XLEN-1:0]  rs1_data;
   logic [XLEN-1:0]  rs2_data;
   logic [XLEN-1:0]  dbg_data;
   logic [XLEN-1:0]  wb_data;
   logic [CNT_W-1:0] retire_cnt;

   modport master (
      output WB_RegWrite, WB_MemtoReg, WB_link, WB_rd_addr,
      output WB_ALUResult, WB_MemData, WB_pc4_i,
      output rs1_addr, rs2_addr, dbg_addr,
      input  rs1_data, rs2_data, dbg_data, wb_data, retire_cnt
   );

   modport slave (
      input  WB_RegWrite, WB_MemtoReg, WB_link, WB_rd_addr,
      input  WB_ALUResult, WB_MemData, WB_pc4_i,
      input  rs1_addr, rs2_addr, dbg_addr,
      output rs1_data, rs2_data, dbg_data, wb_data, retire_cnt
   );
endinterface

// File: rtl/wb_regfile.sv
// Write-back mux, 32x32 integer register file with async reads, and retired-write counter.
// Optional REGFILE_BYPASS_EN: rs1/rs2 see the value being written in the same cycle.
module wb_regfile #(
   parameter int XLEN  = 32,
   parameter int NREG  = 32,
   parameter int CNT_W = 32
) (
   input logic         clk,
   input logic         rst,
   wb_regfile_if.slave bus
);
   logic [XLEN-1:0]  regs [NREG];
   logic [XLEN-1:0]  wb_sel;
   logic             commit;
   logic [CNT_W-1:0] cnt_reg;

   assign wb_sel      = bus.WB_link     ? bus.WB_pc4_i  :
                        bus.WB_MemtoReg ? bus.WB_MemData : bus.WB_ALUResult;
   assign commit      = bus.WB_RegWrite && (bus.WB_rd_addr != 5'd0);
   assign bus.wb_data = wb_sel;

   // One flop row per register so each gets its own enable; x0 stays a constant zero.
   generate
      for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
         if (gi == 0) begin : g_zero
            always_ff @(posedge clk) begin
               regs[gi] <= '0;
            end
         end else begin : g_row
            always_ff @(posedge clk) begin
               if (rst) begin
                  regs[gi] <= '0;
               end else if (commit && (bus.WB_rd_addr == 5'(gi))) begin
                  regs[gi] <= wb_sel;
               end
            end
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_reg <= '0;
      end else if (commit) begin
         cnt_reg <= cnt_reg + 1'b1;
      end
   end

   assign bus.retire_cnt = cnt_reg;

   always_comb begin
      bus.rs1_data = (bus.rs1_addr == 5'd0) ? '0 : regs[bus.rs1_addr];
      bus.rs2_data = (bus.rs2_addr == 5'd0) ? '0 : regs[bus.rs2_addr];
      bus.dbg_data = (bus.dbg_addr == 5'd0) ? '0 : regs[bus.dbg_addr];
`ifdef REGFILE_BYPASS_EN
      // Write-through for the ID ports only; the debug port always shows committed state.
      if (commit && (bus.rs1_addr == bus.WB_rd_addr)) begin
         bus.rs1_data = wb_sel;
      end
      if (commit && (bus.rs2_addr == bus.WB_rd_addr)) begin
         bus.rs2_data = wb_sel;
      end
`else
`endif
   end
endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: expected port values are queued when a cycle is driven and
// compared once outputs settle. Uses CNT_W=4 so counter wrap is reachable.
module tb_wb_regfile;
   localparam int XLEN  = 32;
   localparam int CNT_W = 4;
`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   typedef struct {
      string       tag;
      int          port;   // 0 rs1, 1 rs2, 2 dbg, 3 wb_data, 4 retire_cnt
      logic [31:0] value;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   failures = 0;
   int   txn = 0;
   exp_t exp_q[$];

   logic [31:0]      mregs [32];
   logic [CNT_W-1:0] mcnt;

   wb_regfile_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

   wb_regfile #(.XLEN(XLEN), .NREG(32), .CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] observe(input int port);
      case (port)
         0:       return bus.rs1_data;
         1:       return bus.rs2_data;
         2:       return bus.dbg_data;
         3:       return bus.wb_data;
         default: return 32'(bus.retire_cnt);
      endcase
   endfunction

   // Drives one cycle at negedge, queues expected outputs, compares them, then updates the model
   // with what the DUT commits at the following posedge.
   task automatic cycle(input logic r, input logic we, input logic m2r, input logic lnk,
                        input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] mem,
                        input logic [31:0] pc4, input logic [4:0] a1, input logic [4:0] a2,
                        input logic [4:0] ad, input bit chk_state, input bit chk_wb);
      logic [31:0] wsel;
      logic        wr;
      exp_t        e;
      @(negedge clk);
      rst = r;
      bus.WB_RegWrite = we;  bus.WB_MemtoReg = m2r;  bus.WB_link = lnk;
      bus.WB_rd_addr = rd;   bus.WB_ALUResult = alu; bus.WB_MemData = mem;
      bus.WB_pc4_i = pc4;    bus.rs1_addr = a1;      bus.rs2_addr = a2;
      bus.dbg_addr = ad;
      wsel = lnk ? pc4 : (m2r ? mem : alu);
      wr   = we && (rd != 5'd0);
      if (chk_state) begin
         exp_q.push_back('{"rs1", 0, (a1 == 5'd0) ? 32'd0 : ((BYP && wr && a1 == rd) ? wsel : mregs[a1])});
         exp_q.push_back('{"rs2", 1, (a2 == 5'd0) ? 32'd0 : ((BYP && wr && a2 == rd) ? wsel : mregs[a2])});
         exp_q.push_back('{"dbg", 2, (ad == 5'd0) ? 32'd0 : mregs[ad]});
         exp_q.push_back('{"retire_cnt", 4, 32'(mcnt)});
      end
      if (chk_wb) exp_q.push_back('{"wb_data", 3, wsel});
      #1;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check(e.tag, observe(e.port), e.value);
      end
      $display("txn %0d rst=%0b we=%0b rd=%0d wb=%08h rs1[%0d]=%08h rs2[%0d]=%08h dbg[%0d]=%08h cnt=%0d",
               txn, r, we, rd, bus.wb_data, a1, bus.rs1_data, a2, bus.rs2_data, ad, bus.dbg_data,
               bus.retire_cnt);
      txn++;
      if (r) begin
         for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
         mcnt = '0;
      end else if (wr) begin
         mregs[rd] = wsel;
         mcnt = mcnt + 1'b1;
      end
   endtask

   task automatic wr_alu(input logic [4:0] rd, input logic [31:0] v);
      cycle(1'b0, 1'b1, 1'b0, 1'b0, rd, v, 32'h0, 32'h0, rd, 5'd0, rd, 1'b1, 1'b1);
   endtask

   task automatic rd3(input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] ad);
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, a1, a2, ad, 1'b1, 1'b1);
   endtask

   initial begin
      for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
      mcnt = '0;
      // Reset cycle: pre-reset state is unknown, so only the combinational mux is checked.
      cycle(1'b1, 1'b1, 1'b0, 1'b0, 5'd9, 32'h1111_2222, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
      for (int i = 0; i < 32; i++) rd3(5'(i), 5'(31 - i), 5'(i));

      // ALU and load write-back, each also read in the commit cycle.
      wr_alu(5'd5, 32'h1234_5678);
      rd3(5'd5, 5'd5, 5'd5);
      cycle(1'b0, 1'b1, 1'b1, 1'b0, 5'd6, 32'h0BAD_0BAD, 32'hDEAD_BEEF, 32'h0, 5'd0, 5'd6, 5'd6, 1'b1, 1'b1);
      rd3(5'd5, 5'd6, 5'd6);
      check("cnt_after_two", 32'(bus.retire_cnt), 32'd2);

      // Link overrides MemtoReg.
      cycle(1'b0, 1'b1, 1'b1, 1'b1, 5'd1, 32'h0BAD_0001, 32'h0BAD_0002, 32'h0000_0104, 5'd1, 5'd1, 5'd1, 1'b1, 1'b1);
      rd3(5'd1, 5'd5, 5'd1);

      // Writes to x0 are dropped and not counted.
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'hFFFF_FFFF, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
      rd3(5'd0, 5'd0, 5'd0);

      // Same-cycle read of a register being overwritten.
      wr_alu(5'd7, 32'hAAAA_AAAA);
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 5'd7, 32'h5555_5555, 32'h0, 32'h0, 5'd7, 5'd7, 5'd7, 1'b1, 1'b1);
      rd3(5'd7, 5'd7, 5'd7);

      // Undefined operands with RegWrite low must leave state alone.
      cycle(1'b0, 1'b0, 1'bx, 1'bx, 5'd7, 32'hxxxx_xxxx, 32'hxxxx_xxxx, 32'hxxxx_xxxx, 5'd7, 5'd5, 5'd6, 1'b1, 1'b0);
      rd3(5'd7, 5'd5, 5'd6);

      // Random mixed traffic.
      for (int i = 0; i < 40; i++) begin
         cycle(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
               5'($urandom_range(0, 31)), $urandom, $urandom, $urandom,
               5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 1'b1, 1'b1);
      end

      // Reset together with a write: the write is discarded and all state clears.
      wr_alu(5'd3, 32'h0000_0042);
      cycle(1'b1, 1'b1, 1'b0, 1'b0, 5'd4, 32'h0000_0077, 32'h0, 32'h0, 5'd3, 5'd4, 5'd3, 1'b1, 1'b1);
      rd3(5'd3, 5'd4, 5'd3);
      check("cnt_after_rst", 32'(bus.retire_cnt), 32'd0);

      // Counter wrap in the 4-bit build.
      for (int i = 0; i < 15; i++) wr_alu(5'(i + 1), 32'(i * 3 + 1));
      rd3(5'd15, 5'd1, 5'd8);
      check("cnt_max", 32'(bus.retire_cnt), 32'd15);
      wr_alu(5'd16, 32'hCAFE_F00D);
      rd3(5'd16, 5'd15, 5'd16);
      check("cnt_wrap", 32'(bus.retire_cnt), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
